// File: rtl/window_scan_feeder_if.sv
// Handshake and data bundle between the window scan feeder, its frame memory,
// the 3x3 window buffer and the downstream filter stage.
interface window_scan_feeder_if #(
   parameter int ADDR_W  = 8,
   parameter int PIXEL_W = 8
);
   logic                    start;
   logic                    mem_rd_en;
   logic [ADDR_W-1:0]       mem_addr;
   logic [PIXEL_W-1:0]      mem_rd_data;
   logic                    shift_enable;
   logic [1:0]              shift_direction;
   logic [0:2][PIXEL_W-1:0] buffer_input;
   logic                    window_valid;
   logic                    consumer_ready;
   logic [ADDR_W-1:0]       win_row;
   logic [ADDR_W-1:0]       win_col;
   logic                    busy;
   logic                    done;

   modport master (
      input  start, mem_rd_data, consumer_ready,
      output mem_rd_en, mem_addr, shift_enable, shift_direction, buffer_input,
             window_valid, win_row, win_col, busy, done
   );

   modport slave (
      output start, mem_rd_data, consumer_ready,
      input  mem_rd_en, mem_addr, shift_enable, shift_direction, buffer_input,
             window_valid, win_row, win_col, busy, done
   );
endinterface

// File: rtl/window_scan_feeder.sv
// Walks a 3x3 window buffer over the frame in serpentine order, fetching one
// new column or row per step and presenting each complete window downstream.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FETCH   | three memory reads for the next column/row (k = 0..2)
// S_CAPTURE | last read data lands in buffer_input
// S_SHIFT   | one-cycle shift strobe into the window buffer
// S_PRESENT | window_valid held until consumer_ready
// S_DONE    | one-cycle end-of-frame pulse
module window_scan_feeder #(
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16,
   parameter int PIXEL_W    = 8,
   parameter int ADDR_W     = 8
) (
   input logic                clk,
   input logic                n_rst,
   window_scan_feeder_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_SHIFT, S_PRESENT, S_DONE
   } state_t;

   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;
   localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(IMG_WIDTH);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_HEIGHT - 1);

   state_t                  state, state_nx;
   logic [1:0]              rd_k, cap_k, fill_cnt, step_dir;
   logic                    cap_en, dir_right;
   logic [ADDR_W-1:0]       top, left;
   logic [0:2][PIXEL_W-1:0] buf_q;

   logic                    filling;
   logic [ADDR_W-1:0]       rd_row, rd_col, k_a;
   logic                    at_row_end, next_done;
   logic [1:0]              next_step;

   assign filling          = (fill_cnt != 2'd3);
   assign bus.buffer_input = buf_q;

   // Source pixel of read k for the pending step; fill steps load columns 0..2.
   always_comb begin
      k_a    = ADDR_W'(rd_k);
      rd_row = '0;
      rd_col = '0;
      if (filling) begin
         rd_row = k_a;
         rd_col = ADDR_W'(fill_cnt);
      end else begin
         case (step_dir)
            DIR_RIGHT: begin
               rd_row = top + k_a;
               rd_col = left + ADDR_W'(3);
            end
            DIR_LEFT: begin
               rd_row = top + k_a;
               rd_col = left - ADDR_W'(1);
            end
            default: begin
               rd_row = top + ADDR_W'(3);
               rd_col = left + k_a;
            end
         endcase
      end
   end

   always_comb begin
      next_step  = DIR_DOWN;
      next_done  = 1'b0;
      at_row_end = dir_right ? (left + ADDR_W'(2) == LAST_COL) : (left == '0);
      if (!at_row_end) begin
         next_step = dir_right ? DIR_RIGHT : DIR_LEFT;
      end else if (top + ADDR_W'(2) < LAST_ROW) begin
         next_step = DIR_DOWN;
      end else begin
         next_done = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx            = state;
      bus.mem_rd_en       = 1'b0;
      bus.mem_addr        = '0;
      bus.shift_enable    = 1'b0;
      bus.shift_direction = 2'b00;
      bus.window_valid    = 1'b0;
      bus.win_row         = '0;
      bus.win_col         = '0;
      bus.busy            = 1'b0;
      bus.done            = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            bus.busy      = 1'b1;
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = rd_row * WIDTH_A + rd_col;
            if (rd_k == 2'd2) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            bus.busy = 1'b1;
            state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            bus.busy            = 1'b1;
            bus.shift_enable    = 1'b1;
            bus.shift_direction = step_dir;
            state_nx = (filling && fill_cnt != 2'd2) ? S_FETCH : S_PRESENT;
         end
         S_PRESENT: begin
            bus.busy         = 1'b1;
            bus.window_valid = 1'b1;
            bus.win_row      = top + ADDR_W'(1);
            bus.win_col      = left + ADDR_W'(1);
            if (bus.consumer_ready) state_nx = next_done ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Read data arrives one cycle after the strobe; remember which slot it fills.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rd_k      <= '0;
         cap_k     <= '0;
         cap_en    <= 1'b0;
         fill_cnt  <= '0;
         step_dir  <= DIR_RIGHT;
         dir_right <= 1'b1;
         top       <= '0;
         left      <= '0;
         buf_q     <= '0;
      end else begin
         cap_en <= bus.mem_rd_en;
         cap_k  <= rd_k;
         if (cap_en) buf_q[cap_k] <= bus.mem_rd_data;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  rd_k      <= '0;
                  fill_cnt  <= '0;
                  step_dir  <= DIR_RIGHT;
                  dir_right <= 1'b1;
                  top       <= '0;
                  left      <= '0;
               end
            end
            S_FETCH: rd_k <= (rd_k == 2'd2) ? 2'd0 : rd_k + 2'd1;
            S_SHIFT: begin
               if (filling) begin
                  fill_cnt <= fill_cnt + 2'd1;
               end else begin
                  case (step_dir)
                     DIR_RIGHT: left <= left + ADDR_W'(1);
                     DIR_LEFT:  left <= left - ADDR_W'(1);
                     default:   top  <= top + ADDR_W'(1);
                  endcase
               end
            end
            S_PRESENT: begin
               if (bus.consumer_ready && !next_done) begin
                  step_dir <= next_step;
                  if (next_step == DIR_DOWN) dir_right <= !dir_right;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_window_scan_feeder.sv
// Bench for window_scan_feeder: three instances (3x3, 4x4, 16x16) checked
// against a geometric serpentine model of shifts and window centres.
module tb_window_scan_feeder;
   localparam int NI   = 3;
   localparam int LOGN = 2048;

   function automatic int wid(input int i);
      return (i == 0) ? 3 : ((i == 1) ? 4 : 16);
   endfunction

   function automatic logic [7:0] pix(input int r, input int c, input int w);
      return 8'((r * w + c) % 256);
   endfunction

   logic tb_clk = 1'b0;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;

   logic        start_v [NI];
   logic        ready_v [NI];
   logic        sh_en   [NI];
   logic        wv      [NI];
   logic        rd_en   [NI];
   logic        busy_v  [NI];
   logic        done_v  [NI];
   logic [1:0]  sh_dir  [NI];
   logic [23:0] bin     [NI];
   logic [7:0]  wr      [NI];
   logic [7:0]  wc      [NI];
   logic [54:0] outs_v  [NI];

   logic [25:0] sh_log  [NI][LOGN];
   logic [15:0] win_log [NI][LOGN];
   int          sh_n [NI];
   int          win_n[NI];
   int          done_n[NI];
   int          ovl_n[NI];

   logic [25:0] exp_sh [LOGN];
   logic [15:0] exp_win[LOGN];
   int          exp_nsh, exp_nwin;

   always #5 tb_clk = ~tb_clk;

   window_scan_feeder_if #(.ADDR_W(8), .PIXEL_W(8)) bus [NI] ();

   for (genvar g = 0; g < NI; g++) begin : g_dut
      window_scan_feeder #(
         .IMG_WIDTH(wid(g)), .IMG_HEIGHT(wid(g)), .PIXEL_W(8), .ADDR_W(8)
      ) dut (
         .clk(tb_clk), .n_rst(n_rst), .bus(bus[g])
      );
      assign bus[g].start          = start_v[g];
      assign bus[g].consumer_ready = ready_v[g];
      assign sh_en[g]  = bus[g].shift_enable;
      assign sh_dir[g] = bus[g].shift_direction;
      assign bin[g]    = bus[g].buffer_input;
      assign wv[g]     = bus[g].window_valid;
      assign rd_en[g]  = bus[g].mem_rd_en;
      assign busy_v[g] = bus[g].busy;
      assign done_v[g] = bus[g].done;
      assign wr[g]     = bus[g].win_row;
      assign wc[g]     = bus[g].win_col;
      assign outs_v[g] = {bus[g].mem_rd_en, bus[g].mem_addr, bus[g].shift_enable,
                          bus[g].shift_direction, bus[g].buffer_input, bus[g].window_valid,
                          bus[g].win_row, bus[g].win_col, bus[g].busy, bus[g].done};
      // Frame memory: pixel = address mod 256, data one cycle after the strobe.
      always_ff @(posedge tb_clk) begin
         if (bus[g].mem_rd_en) bus[g].mem_rd_data <= bus[g].mem_addr;
      end
   end

   always @(negedge tb_clk) begin
      for (int i = 0; i < NI; i++) begin
         if (sh_en[i] && sh_n[i] < LOGN) begin
            sh_log[i][sh_n[i]] <= {sh_dir[i], bin[i]};
            sh_n[i] <= sh_n[i] + 1;
         end
         if (wv[i] && ready_v[i] && win_n[i] < LOGN) begin
            win_log[i][win_n[i]] <= {wr[i], wc[i]};
            win_n[i] <= win_n[i] + 1;
         end
         if (done_v[i]) done_n[i] <= done_n[i] + 1;
         if (sh_en[i] && wv[i]) ovl_n[i] <= ovl_n[i] + 1;
      end
   end

   // Serpentine reference: windows row-band by row-band, alternating direction.
   task automatic build_model(input int w, input int h);
      int  prev_top, prev_left, left;
      bit  first;
      exp_nsh  = 0;
      exp_nwin = 0;
      for (int f = 0; f < 3; f++) begin
         exp_sh[exp_nsh] = {2'b01, pix(0, f, w), pix(1, f, w), pix(2, f, w)};
         exp_nsh++;
      end
      first = 1'b1; prev_top = 0; prev_left = 0;
      for (int t = 0; t <= h - 3; t++) begin
         for (int j = 0; j <= w - 3; j++) begin
            left = (t % 2 == 0) ? j : (w - 3 - j);
            if (!first) begin
               if (t != prev_top)
                  exp_sh[exp_nsh] = {2'b11, pix(t+2, left, w), pix(t+2, left+1, w), pix(t+2, left+2, w)};
               else if (left > prev_left)
                  exp_sh[exp_nsh] = {2'b01, pix(t, left+2, w), pix(t+1, left+2, w), pix(t+2, left+2, w)};
               else
                  exp_sh[exp_nsh] = {2'b10, pix(t, left, w), pix(t+1, left, w), pix(t+2, left, w)};
               exp_nsh++;
            end
            exp_win[exp_nwin] = {8'(t + 1), 8'(left + 1)};
            exp_nwin++;
            first = 1'b0; prev_top = t; prev_left = left;
         end
      end
   endtask

   task automatic pulse_start(input int i);
      @(posedge tb_clk); #1;
      start_v[i] = 1'b1;
      @(posedge tb_clk); #1;
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input bit rand_ready, input bit poke, output bit got);
      got = 1'b0;
      for (int cyc = 0; cyc < 30000 && !got; cyc++) begin
         @(posedge tb_clk); #1;
         if (done_v[i]) got = 1'b1;
         ready_v[i] = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         start_v[i] = poke && busy_v[i] && ($urandom_range(0, 5) == 0);
      end
      start_v[i] = 1'b0;
      ready_v[i] = 1'b1;
      @(negedge tb_clk); #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(posedge tb_clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (outs_v[i] !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst%0d got %h exp 0", i, outs_v[i]);
         end
      end
      n_rst = 1'b1;
   endtask

   task automatic test_frame_scan(input int i, input bit rand_ready, input bit poke);
      int sh0, win0, dn0, ov0;
      bit got;
      build_model(wid(i), wid(i));
      sh0 = sh_n[i]; win0 = win_n[i]; dn0 = done_n[i]; ov0 = ovl_n[i];
      pulse_start(i);
      wait_done(i, rand_ready, poke, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL frame_timeout inst%0d got no done exp done", i);
      end
      checks++;
      if (sh_n[i] - sh0 != exp_nsh) begin
         errors++;
         $display("FAIL shift_count inst%0d got %0d exp %0d", i, sh_n[i] - sh0, exp_nsh);
      end
      for (int k = 0; k < exp_nsh && sh0 + k < LOGN; k++) begin
         checks++;
         if (sh_log[i][sh0 + k] !== exp_sh[k]) begin
            errors++;
            $display("FAIL shift_%0d inst%0d got %h exp %h", k, i, sh_log[i][sh0 + k], exp_sh[k]);
         end
      end
      checks++;
      if (win_n[i] - win0 != exp_nwin) begin
         errors++;
         $display("FAIL window_count inst%0d got %0d exp %0d", i, win_n[i] - win0, exp_nwin);
      end
      for (int k = 0; k < exp_nwin && win0 + k < LOGN; k++) begin
         checks++;
         if (win_log[i][win0 + k] !== exp_win[k]) begin
            errors++;
            $display("FAIL window_%0d inst%0d got %h exp %h", k, i, win_log[i][win0 + k], exp_win[k]);
         end
      end
      checks++;
      if (done_n[i] - dn0 != 1) begin
         errors++;
         $display("FAIL done_pulses inst%0d got %0d exp 1", i, done_n[i] - dn0);
      end
      checks++;
      if (ovl_n[i] != ov0) begin
         errors++;
         $display("FAIL valid_shift_overlap inst%0d got %0d exp 0", i, ovl_n[i] - ov0);
      end
   endtask

   task automatic test_back_pressure();
      bit got;
      ready_v[1] = 1'b0;
      pulse_start(1);
      got = 1'b0;
      for (int cyc = 0; cyc < 200 && !got; cyc++) begin
         if (wv[1]) got = 1'b1;
         else begin
            @(posedge tb_clk); #1;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_window_timeout got no window_valid exp window_valid");
      end
      for (int n = 0; n < 10; n++) begin
         @(posedge tb_clk); #1;
         checks++;
         if ({wv[1], rd_en[1], sh_en[1], wr[1], wc[1]} !== {3'b100, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL bp_hold_%0d got %b_%0d_%0d exp 100_1_1", n,
                     {wv[1], rd_en[1], sh_en[1]}, wr[1], wc[1]);
         end
      end
      ready_v[1] = 1'b1;
      @(posedge tb_clk); #1;
      checks++;
      if ({wv[1], rd_en[1]} !== 2'b01) begin
         errors++;
         $display("FAIL bp_resume got valid/rd %b exp 01", {wv[1], rd_en[1]});
      end
      wait_done(1, 1'b0, 1'b0, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_done_timeout got no done exp done");
      end
   endtask

   task automatic test_reset_mid_fetch();
      int  win0, dn0;
      bit  got;
      pulse_start(2);
      @(posedge tb_clk); #1;
      n_rst = 1'b0;
      @(posedge tb_clk); #1;
      checks++;
      if (outs_v[2] !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %h exp 0", outs_v[2]);
      end
      n_rst = 1'b1;
      @(posedge tb_clk); #1;
      win0 = win_n[2]; dn0 = done_n[2];
      pulse_start(2);
      got = 1'b0;
      for (int cyc = 0; cyc < 200 && !got; cyc++) begin
         if (wv[2]) got = 1'b1;
         else begin
            @(posedge tb_clk); #1;
         end
      end
      checks++;
      if (!got || {wr[2], wc[2]} !== {8'd1, 8'd1}) begin
         errors++;
         $display("FAIL restart_first_centre got %0d,%0d exp 1,1", wr[2], wc[2]);
      end
      wait_done(2, 1'b0, 1'b0, got);
      checks++;
      if (!got || win_n[2] - win0 != 196 || done_n[2] - dn0 != 1) begin
         errors++;
         $display("FAIL restart_frame got windows %0d done %0d exp 196 1",
                  win_n[2] - win0, done_n[2] - dn0);
      end
   endtask

   task automatic test_timing();
      bit got;
      @(posedge tb_clk); #1;
      start_v[2] = 1'b1;
      checks++;
      if (rd_en[2] !== 1'b0) begin
         errors++;
         $display("FAIL timing_pre_start got rd_en %b exp 0", rd_en[2]);
      end
      @(posedge tb_clk); #1;
      start_v[2] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rd_en[2], sh_en[2]} !== {(c < 3) ? 1'b1 : 1'b0, (c == 4) ? 1'b1 : 1'b0}) begin
               errors++;
               $display("FAIL timing_step%0d_cyc%0d got rd/shift %b exp %b%b", s, c,
                        {rd_en[2], sh_en[2]}, (c < 3) ? 1'b1 : 1'b0, (c == 4) ? 1'b1 : 1'b0);
            end
            @(posedge tb_clk); #1;
         end
      end
      checks++;
      if (wv[2] !== 1'b1) begin
         errors++;
         $display("FAIL timing_first_window got valid %b exp 1", wv[2]);
      end
      wait_done(2, 1'b0, 1'b0, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL timing_done_timeout got no done exp done");
      end
   endtask

   initial begin
      n_rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start_v[i] = 1'b0;
         ready_v[i] = 1'b1;
      end
      test_reset();
      test_frame_scan(0, 1'b0, 1'b0);
      test_frame_scan(1, 1'b1, 1'b0);
      test_back_pressure();
      test_reset_mid_fetch();
      test_frame_scan(2, 1'b1, 1'b1);
      test_timing();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
